chroma_demodulator: RTL and testbench
=====================================

Name: chroma_demodulator

Overview:
Recovers I/Q colour-difference components from an NTSC chroma sample stream on the 6x-subcarrier master clock. It multiplies each incoming chroma sample by the same 6-point cos/sin carrier table the transmit side uses. Products are integrated over exactly one subcarrier cycle (integrate-and-dump), which cancels the 2ω term, and the sums are then scaled back to 8-bit offset-128 I/Q. The block sits on the receive/loopback side of the composite path, feeding the YIQ-to-RGB converter and the chroma self-test checker.

Parameters:
PHASE_LAG, 2, samples by which chroma_in lags hsync-aligned carrier phase 0 (range 0..5); the carrier table index is (phase + 6 - PHASE_LAG) mod 6.
SCALE_MUL, 43, normalisation multiplier; the result is (acc * SCALE_MUL) >>> 14, approximately 1/381.

Ports:
clk_master  in  1  NTSC master clock (~21.48 MHz, 6x subcarrier)
rst_n  in  1  reset, synchronous, active-low
chroma_in  in  8  chroma sample, offset-128 (128 = zero), one sample per clock
hsync  in  1  line sync; resets carrier phase and integration
i_out  out  8  recovered I, offset-128
q_out  out  8  recovered Q, offset-128
iq_valid  out  1  one-cycle pulse when i_out/q_out update
sat_flag  out  1  (only with CHROMA_DEMOD_SAT_EN) sticky saturation indicator

Behaviour:
- One clock, clk_master. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk_master resets the block at that edge.
- Reset values: i_out=128, q_out=128, iq_valid=0, phase=0, accumulators=0, pipeline registers=0, sat_flag=0.
- Phase counter, 3 bits:
  - Counts 0..5 and wraps to 0.
  - hsync high at an edge forces phase=0 at that edge.
  - hsync has priority over increment.
- Carrier table (signed 8-bit) at index k=0..5:
  - cos: 127, 64, -64, -127, -64, 64
  - sin: 0, 110, 110, 0, -110, -110
- Stage 1 (registered): c_s = chroma_in - 128, 9-bit signed; registered with the table index for that sample.
- Stage 2 (registered):
  - pi = c_s*cos, pq = c_s*sin, 17-bit signed.
  - Each is added to its 20-bit signed accumulator: acc_i, acc_q.
  - The product belonging to phase 0 loads the accumulator (acc = product) instead of adding.
- Dump:
  - When the product tagged with phase 5 is accumulated, the completed sums are scaled: r = (acc*SCALE_MUL) >>> 14, arithmetic shift, 27-bit intermediate.
  - Saturate r to [-128,127], then add 128.
  - Register the result onto i_out/q_out and pulse iq_valid.
- Latency: samples taken at edges t0..t0+5 (phases 0..5) give i_out/q_out/iq_valid at edge t0+8. iq_valid is high exactly one cycle per 6 samples in steady state.
- hsync mid-block:
  - Phase tags already in the pipeline complete normally.
  - The first sample after hsync is tagged phase 0 and reloads the accumulators, discarding any partial block.
  - A partial block never produces iq_valid.
- Outputs hold their value between iq_valid pulses.
- A constant chroma_in (any value) yields acc=0, so outputs are 128.
- Reset mid-block: all state is cleared at that edge; no iq_valid for the interrupted block.

Optional Feature:
CHROMA_DEMOD_SAT_EN
- Defined: the sat_flag port exists. It is set at any dump where I or Q was clamped, and cleared only on reset or by hsync.
- Undefined: the sat_flag port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ntsc_pkg holds:
  - the 6-entry COS_LUT/SIN_LUT constants, shared with the modulator so both ends stay bit-identical
  - SUBCARRIER_PHASES=6
  - CHROMA_ZERO=128
- Sub-module iq_scale_sat: combinational scale, shift and saturate to offset-128 output. It is instantiated twice, for I and Q.

Test Plan:
1. rst_n low for 3 edges, then chroma_in=128 constant with hsync pulse -> i_out=128, q_out=128, iq_valid pulses every 6 cycles, first at hsync edge+9.
2. Golden modulator model, PHASE_LAG=2, I=228, Q=128 held -> after settling, i_out=228±2, q_out=128±2; likewise Q=48 -> q_out=48±2.
3. chroma_in pattern per phase 0..5 = 255,255,0,0,0,255, aligned -> acc_i=65025, r=170 clamped -> i_out=255 (sat_flag=1 if EN); q_out is not clamped.
4. hsync asserted at phase 3 -> no iq_valid for the truncated block; next iq_valid 9 cycles after hsync edge; values match a clean block.
5. rst_n low for one edge mid-block -> outputs return to 128/0 the next cycle; the first valid after release follows a full 6-sample block.
6. Random I/Q over 1000 blocks through the modulator model -> every decoded pair within ±2 of the input, or saturated consistently.

Source files
------------

// File: rtl/ntsc_pkg.sv
// Shared NTSC chroma constants: the 6-point subcarrier tables used by both the
// modulator and demodulator so the two ends stay bit-identical.
package ntsc_pkg;

  localparam int SUBCARRIER_PHASES = 6;
  localparam int CHROMA_ZERO       = 128;

  localparam logic signed [7:0] COS_LUT [0:SUBCARRIER_PHASES-1] =
    '{8'sd127, 8'sd64, -8'sd64, -8'sd127, -8'sd64, 8'sd64};
  localparam logic signed [7:0] SIN_LUT [0:SUBCARRIER_PHASES-1] =
    '{8'sd0, 8'sd110, 8'sd110, 8'sd0, -8'sd110, -8'sd110};

  typedef struct packed {
    logic signed [8:0] cs;
    logic [2:0]        idx;
  } s1_t;

  // Carrier table index for a sample whose input lags carrier phase 0 by lag.
  function automatic logic [2:0] carrier_idx(input logic [2:0] ph, input int lag);
    int k;
    k = (int'(ph) + SUBCARRIER_PHASES - lag) % SUBCARRIER_PHASES;
    return k[2:0];
  endfunction

endpackage

// File: rtl/iq_scale_sat.sv
// Scales one integrated colour-difference sum back to 8-bit offset-128,
// clamping to the signed 8-bit range first.
module iq_scale_sat #(
  parameter int SCALE_MUL = 43
) (
  input  logic signed [19:0] acc,
  output logic [7:0]         val,
  output logic               clamped
);
  logic signed [26:0] prod;
  logic signed [26:0] r;

  assign prod = 27'(acc) * 27'(SCALE_MUL);
  assign r    = prod >>> 14;

  always_comb begin
    val     = {~r[7], r[6:0]};
    clamped = 1'b0;
    if (r > 27'sd127) begin
      val     = 8'd255;
      clamped = 1'b1;
    end else if (r < -27'sd128) begin
      val     = 8'd0;
      clamped = 1'b1;
    end
  end
endmodule

// File: rtl/chroma_demodulator.sv
// NTSC chroma I/Q demodulator: carrier multiply, integrate-and-dump over one
// subcarrier cycle, scale to offset-128. CHROMA_DEMOD_SAT_EN adds sat_flag.
module chroma_demodulator
  import ntsc_pkg::*;
#(
  parameter int PHASE_LAG = 2,
  parameter int SCALE_MUL = 43
) (
  input  logic       clk_master,
  input  logic       rst_n,
  input  logic [7:0] chroma_in,
  input  logic       hsync,
  output logic [7:0] i_out,
  output logic [7:0] q_out,
  output logic       iq_valid
`ifdef CHROMA_DEMOD_SAT_EN
  ,
  output logic       sat_flag
`endif
);
  logic [2:0]         phase;
  s1_t                s1;
  logic signed [16:0] pi, pq;
  logic signed [19:0] acc_i, acc_q;
  // Block-start / block-end tags travelling alongside the data.
  logic [2:1]         load_pipe;
  logic [3:1]         dump_pipe;
  logic [7:0]         i_val, q_val;
  logic               i_clamp, q_clamp;

  iq_scale_sat #(.SCALE_MUL(SCALE_MUL)) u_scale_i (.acc(acc_i), .val(i_val), .clamped(i_clamp));
  iq_scale_sat #(.SCALE_MUL(SCALE_MUL)) u_scale_q (.acc(acc_q), .val(q_val), .clamped(q_clamp));

  always_ff @(posedge clk_master) begin
    if (!rst_n) begin
      phase     <= '0;
      s1        <= '0;
      pi        <= '0;
      pq        <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      load_pipe <= '0;
      dump_pipe <= '0;
      i_out     <= 8'(CHROMA_ZERO);
      q_out     <= 8'(CHROMA_ZERO);
      iq_valid  <= 1'b0;
    end else begin
      phase <= (hsync || phase == 3'd5) ? 3'd0 : phase + 3'd1;

      s1.cs        <= {1'b0, chroma_in} - 9'(CHROMA_ZERO);
      s1.idx       <= carrier_idx(phase, PHASE_LAG);
      load_pipe[1] <= (phase == 3'd0);
      dump_pipe[1] <= (phase == 3'd5);

      pi           <= 17'($signed(s1.cs)) * 17'(COS_LUT[s1.idx]);
      pq           <= 17'($signed(s1.cs)) * 17'(SIN_LUT[s1.idx]);
      load_pipe[2] <= load_pipe[1];
      dump_pipe[2] <= dump_pipe[1];

      acc_i        <= load_pipe[2] ? 20'(pi) : acc_i + 20'(pi);
      acc_q        <= load_pipe[2] ? 20'(pq) : acc_q + 20'(pq);
      dump_pipe[3] <= dump_pipe[2];

      iq_valid <= dump_pipe[3];
      if (dump_pipe[3]) begin
        i_out <= i_val;
        q_out <= q_val;
      end
    end
  end

`ifdef CHROMA_DEMOD_SAT_EN
  // A clamp at the same edge as hsync wins so the event is never lost.
  always_ff @(posedge clk_master) begin
    if (!rst_n)
      sat_flag <= 1'b0;
    else if (dump_pipe[3] && (i_clamp || q_clamp))
      sat_flag <= 1'b1;
    else if (hsync)
      sat_flag <= 1'b0;
  end
`else
  logic unused_clamp;
  assign unused_clamp = i_clamp ^ q_clamp;
`endif

endmodule

// File: tb/tb_chroma_demodulator.sv
// Scoreboard bench for chroma_demodulator: golden modulator drives chroma,
// a reference integrate-and-dump predicts each I/Q pair and its arrival edge.
module tb_chroma_demodulator;
  import ntsc_pkg::*;

  logic       clk_master = 1'b0;
  logic       rst_n      = 1'b0;
  logic       hsync      = 1'b0;
  logic [7:0] chroma_in  = 8'd128;
  logic [7:0] i_out, q_out;
  logic       iq_valid;
`ifdef CHROMA_DEMOD_SAT_EN
  logic       sat_flag;
`endif

  always #5 clk_master = ~clk_master;

  chroma_demodulator #(.PHASE_LAG(2), .SCALE_MUL(43)) dut (
    .clk_master(clk_master),
    .rst_n(rst_n),
    .chroma_in(chroma_in),
    .hsync(hsync),
    .i_out(i_out),
    .q_out(q_out),
    .iq_valid(iq_valid)
`ifdef CHROMA_DEMOD_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    int i; int q; int ti; int tq; bit tol; bit sat; int due;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0;
  int   ph = 0, ref_i = 0, ref_q = 0;
  int   held_i = 128, held_q = 128;
  int   tgt_i = 128, tgt_q = 128;
  bit   tgt_tol = 1'b0, sat_m = 1'b0, mon_en = 1'b0;

  always @(posedge clk_master) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int scale(input int acc, output bit clp);
    int r;
    r   = (acc * 43) >>> 14;
    clp = (r > 127) || (r < -128);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r + 128;
  endfunction

  // Transmit-side model: chroma = 128 + round((a*cos + b*sin)/128), clipped.
  function automatic logic [7:0] modulate(input int a, input int b, input int p);
    int k, v, c;
    k = (p + 6 - 2) % 6;
    v = a * int'(COS_LUT[k]) + b * int'(SIN_LUT[k]);
    c = 128 + ((v >= 0) ? (v + 64) / 128 : -((-v + 64) / 128));
    if (c > 255) c = 255;
    if (c < 0)   c = 0;
    return 8'(c);
  endfunction

  task automatic step(input logic [7:0] c, input bit hs, input bit rs);
    int k, cs;
    bit ci, cq;
    exp_t e;
    chroma_in = c; hsync = hs; rst_n = rs;
    @(posedge clk_master); #1;
    if (!rs) begin
      ph = 0; sb.delete();
      held_i = 128; held_q = 128; sat_m = 1'b0;
      chk("rst_i", i_out, 128);
      chk("rst_q", q_out, 128);
      chk("rst_valid", iq_valid, 0);
      return;
    end
    k  = (ph + 6 - 2) % 6;
    cs = int'(c) - 128;
    if (ph == 0) begin
      ref_i = cs * int'(COS_LUT[k]);
      ref_q = cs * int'(SIN_LUT[k]);
    end else begin
      ref_i += cs * int'(COS_LUT[k]);
      ref_q += cs * int'(SIN_LUT[k]);
    end
    if (ph == 5) begin
      e.i = scale(ref_i, ci);
      e.q = scale(ref_q, cq);
      e.ti = tgt_i; e.tq = tgt_q; e.tol = tgt_tol;
      e.sat = ci | cq; e.due = cyc + 3;
      sb.push_back(e);
    end
    if (hs) sat_m = 1'b0;
    ph = hs ? 0 : (ph + 1) % 6;
  endtask

  // Realigns with an hsync, then sends n clean blocks of constant I/Q.
  task automatic send_iq(input int ti, input int tq, input int n);
    tgt_tol = 1'b0;
    step(modulate(ti - 128, tq - 128, ph), 1'b1, 1'b1);
    tgt_i = ti; tgt_q = tq; tgt_tol = 1'b1;
    repeat (6 * n) step(modulate(ti - 128, tq - 128, ph), 1'b0, 1'b1);
  endtask

  always @(negedge clk_master) begin
    exp_t e;
    int di, dq;
    if (mon_en) begin
      if (iq_valid === 1'b1) begin
        if (sb.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("i_val", i_out, e.i);
          chk("q_val", q_out, e.q);
          chk("latency", cyc, e.due);
          if (e.tol) begin
            di = int'(i_out) - e.ti;
            dq = int'(q_out) - e.tq;
            chk("i_tol", (di <= 2 && di >= -2), 1);
            chk("q_tol", (dq <= 2 && dq >= -2), 1);
          end
          if (e.sat) sat_m = 1'b1;
`ifdef CHROMA_DEMOD_SAT_EN
          chk("sat_flag", sat_flag, sat_m);
`endif
          held_i = e.i; held_q = e.q;
        end
      end else begin
        chk("hold_i", i_out, held_i);
        chk("hold_q", q_out, held_q);
      end
    end
  end

  logic [7:0] pat [0:5];

  initial begin
    pat[0] = 8'd255; pat[1] = 8'd255; pat[2] = 8'd0;
    pat[3] = 8'd0;   pat[4] = 8'd0;   pat[5] = 8'd255;

    // reset, then constant chroma after an hsync
    repeat (3) step(8'd128, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(8'd128, 1'b1, 1'b1);
    repeat (24) step(8'd128, 1'b0, 1'b1);
    step(8'd77, 1'b1, 1'b1);
    repeat (18) step(8'd77, 1'b0, 1'b1);

    // golden modulator, fixed I/Q
    send_iq(228, 128, 4);
    send_iq(128, 48, 4);
    send_iq(60, 190, 4);

    // saturating pattern aligned to the carrier table
    tgt_tol = 1'b0;
    step(8'd128, 1'b1, 1'b1);
    repeat (12) step(pat[(ph + 4) % 6], 1'b0, 1'b1);
    send_iq(128, 128, 2);

    // hsync at phase 3 truncates the block
    send_iq(180, 90, 2);
    while (ph != 3) step(modulate(52, -38, ph), 1'b0, 1'b1);
    tgt_tol = 1'b0;
    step(modulate(52, -38, ph), 1'b1, 1'b1);
    tgt_tol = 1'b1;
    repeat (12) step(modulate(52, -38, ph), 1'b0, 1'b1);

    // one-edge reset mid-block
    while (ph != 2) step(modulate(52, -38, ph), 1'b0, 1'b1);
    step(8'd200, 1'b0, 1'b0);
    tgt_i = 110; tgt_q = 170; tgt_tol = 1'b1;
    repeat (18) step(modulate(-18, 42, ph), 1'b0, 1'b1);

    // random I/Q, one pair per block
    send_iq(128, 128, 1);
    for (int b = 0; b < 1000; b++) begin
      int a, q;
      a = int'($urandom_range(160)) - 80;
      q = int'($urandom_range(160)) - 80;
      tgt_i = a + 128; tgt_q = q + 128;
      repeat (6) step(modulate(a, q, ph), 1'b0, 1'b1);
    end

    // drain with hsync held so no new block completes
    tgt_tol = 1'b0;
    repeat (5) step(8'd128, 1'b1, 1'b1);
    chk("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
